// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Imported by the interface, the top level and its sub-module.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // A 1-bit counter is still needed at the smallest legal width, so $clog2 is floored at 1.
   function automatic int cntWidth(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bus between a controller (master) and the serial subtractor (slave).
// Operands travel with start; the result and flags come back with done.
interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             ovf;

   modport master (
      output start,
      output a,
      output b,
      output b_in,
      input  busy,
      input  done,
      input  diff,
      input  b_out,
      input  ovf
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  b_in,
      output busy,
      output done,
      output diff,
      output b_out,
      output ovf
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational subtractor cell: x - y - bin = d - 2*bout.
// The borrow chain of the serial subtractor is built by reusing this cell over time.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_xorXy;

   assign w_xorXy = x ^ y;
   assign d       = w_xorXy ^ bin;
   assign bout    = (~x & y) | (~w_xorXy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// A start/done handshake wraps the shift loop; results hold until the next operation completes.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = cntWidth(WIDTH);

   state_t             r_state;
   logic [WIDTH-1:0]   r_aShift;
   logic [WIDTH-1:0]   r_bShift;
   logic               r_borrow;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_diff;
   logic               r_bOut;
   logic               r_ovf;

   logic               w_diffBit;
   logic               w_borrowNext;
   logic               w_lastBit;
   logic               w_accept;
   logic [WIDTH-1:0]   w_resultNext;

   full_subtractor u_cell (
      .x    (r_aShift[0]),
      .y    (r_bShift[0]),
      .bin  (r_borrow),
      .d    (w_diffBit),
      .bout (w_borrowNext)
   );

   assign w_lastBit = (r_count == CNT_W'(WIDTH - 1));
   assign w_accept  = bus.start && (r_state != SHIFT);

   // The minuend register doubles as the result register: each consumed a bit frees the MSB slot.
   assign w_resultNext = {w_diffBit, r_aShift[WIDTH-1:1]};

   // State, operand shifting and result capture; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_aShift <= '0;
         r_bShift <= '0;
         r_borrow <= 1'b0;
         r_count  <= '0;
         r_diff   <= '0;
         r_bOut   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_aShift <= bus.a;
                  r_bShift <= bus.b;
                  r_borrow <= bus.b_in;
                  r_count  <= '0;
                  r_state  <= SHIFT;
               end else begin
                  r_state  <= IDLE;
               end
            end
            SHIFT: begin
               r_aShift <= w_resultNext;
               r_bShift <= {1'b0, r_bShift[WIDTH-1:1]};
               r_borrow <= w_borrowNext;
               r_count  <= r_count + 1'b1;
               // Overflow compares the borrow into the MSB cell with the borrow out of it.
               if (w_lastBit) begin
                  r_diff  <= w_resultNext;
                  r_bOut  <= w_borrowNext;
                  r_ovf   <= r_borrow ^ w_borrowNext;
                  r_state <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = (r_state == SHIFT);
   assign bus.done  = (r_state == DONE);
   assign bus.diff  = r_diff;
   assign bus.b_out = r_bOut;
   assign bus.ovf   = r_ovf;

endmodule
